demux_stream_router: RTL
========================

// Module: demux_stream_router
// PURPOSE
//  Parametrised 1-to-NUM_CH demultiplexer for DATA_W-bit words with valid/ready handshake.
//  Each channel owns a one-entry output register, so a stalled channel does not block others.
//  Supports unicast (by in_sel) and broadcast modes, and counts words dropped for bad selects.
//  Successor to the single-bit combinational demux cells; sits between a producer and N consumers.
// PARAMETERS
//  DATA_W   8   payload width in bits (>=1)
//  NUM_CH   4   number of output channels (2..16)
//  SEL_W    2   select width; must satisfy 2**SEL_W >= NUM_CH
//  CNT_W    8   width of drop counter (saturating)
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              asynchronous, active-high reset
//  in_valid   in   1              producer has a word
//  in_ready   out  1              router can accept this cycle (combinational)
//  in_data    in   DATA_W         payload
//  in_sel     in   SEL_W          target channel (unicast)
//  in_bcast   in   1              1 = deliver to every channel; in_sel ignored
//  out_valid  out  NUM_CH         per-channel word available
//  out_ready  in   NUM_CH         per-channel consumer accepts
//  out_data   out  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
//  drop_cnt   out  CNT_W          words accepted but discarded (in_sel >= NUM_CH)
// BEHAVIOUR
//  - Reset (async, immediate): out_valid=0, out_data=0, drop_cnt=0; in_ready=0 while rst=1.
//  - Per-channel state: EMPTY (out_valid[k]=0) / FULL (out_valid[k]=1).
//    free[k] = !out_valid[k] | out_ready[k]  (empty, or draining this cycle).
//  - in_ready (rst=0): unicast, in_sel<NUM_CH: free[in_sel]; unicast, in_sel>=NUM_CH: 1;
//    broadcast: AND of free[k] over all k. in_ready never depends on in_valid.
//  - Accept = in_valid & in_ready at rising clk.
//  - Unicast accept, valid sel: channel in_sel loads in_data, out_valid[in_sel]=1 next cycle.
//  - Broadcast accept: all channels load in_data, all out_valid=1 next cycle.
//  - Bad-sel accept (unicast, in_sel>=NUM_CH): no channel loads; drop_cnt+1, holds at 2**CNT_W-1.
//  - Latency: accepted word visible on out_data/out_valid exactly 1 cycle after accept.
//  - Drain: out_valid[k] & out_ready[k] -> channel EMPTY next cycle unless reloaded same cycle.
//  - Simultaneous drain+load on a channel: new word replaces old, out_valid[k] stays 1, no bubble.
//  - out_data[k] holds its value while FULL and stalled; stays at last value when EMPTY.
//  - Non-target channels are unaffected by a unicast accept; drains proceed independently.
//  - in_valid=0: no state change except drains; drop_cnt unchanged.
//  - Reset mid-operation: all held words discarded; no partial update after rst release.
//  - Full throughput: one word per cycle per channel when consumer holds out_ready=1.
// TESTING
//  1 rst=1 then release; out_valid=0000, out_data=0, drop_cnt=0, in_ready=0 during rst.
//  2 Unicast sel=2 data=8'hA5, all out_ready=1 -> next cycle out_valid=0100, ch2=A5, then 0000.
//  3 out_ready[1]=0, send sel=1 data=11 then sel=1 data=22 -> in_ready=0 on 2nd; ch1 holds 11;
//    raise out_ready[1] -> same cycle in_ready=1, 22 loads, out_valid[1] stays 1.
//  4 Broadcast data=3C with out_ready=1011, ch2 FULL -> in_ready=0; set out_ready[2]=1 -> accept,
//    next cycle out_valid=1111, all channels=3C.
//  5 NUM_CH=3, SEL_W=2, in_sel=3, 300 words -> in_ready=1, no out_valid, drop_cnt saturates 255.
//  6 Back-to-back streaming 0..15 round-robin sel, random out_ready; assert async rst mid-stream
//    -> scoreboard: per-channel in-order, no loss/dup before rst; all out_valid=0 immediately.

Source files
------------

// File: rtl/demux_stream_router.sv
`default_nettype none
// ============================================================================
// Module      : demux_stream_router
// Description : 1-to-NUM_CH valid/ready demultiplexer. Each output channel has
//               a one-entry register so a stalled consumer never blocks the
//               other channels. Supports unicast (by in_sel) and broadcast
//               delivery, and keeps a saturating count of words that were
//               accepted with an out-of-range select and discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_stream_router #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         drop_cnt
);

  // Every encodable select value gets a slot so in_sel can index safely
  // even when it addresses a channel that does not exist.
  localparam int          c_sel_span = 1 << SEL_W;
  localparam int unsigned c_num_ch   = NUM_CH;

  // Per-channel occupancy state.
  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_e;

  logic [NUM_CH-1:0]     w_free;
  logic [NUM_CH-1:0]     w_load;
  logic [c_sel_span-1:0] w_free_ext;
  logic                  w_sel_ok;
  logic                  w_ready_raw;
  logic                  w_accept;
  logic                  w_drop;
  logic [CNT_W-1:0]      drop_cnt_d;
  logic [CNT_W-1:0]      drop_cnt_q;

  assign w_sel_ok = (32'(in_sel) < c_num_ch);

  // Widen the per-channel free vector to the full select range (unused slots read as 0).
  always_comb begin
    w_free_ext               = '0;
    w_free_ext[NUM_CH-1:0]   = w_free;
  end

  // Ready decision: a bad select is always accepted (and dropped), broadcast
  // needs every channel free, unicast only needs the addressed one.
  always_comb begin
    w_ready_raw = 1'b1;
    if (in_bcast) begin
      w_ready_raw = &w_free;
    end else if (w_sel_ok) begin
      w_ready_raw = w_free_ext[in_sel];
    end
  end

  assign in_ready = !rst && w_ready_raw;
  assign w_accept = in_valid && in_ready;
  assign w_drop   = w_accept && !in_bcast && !w_sel_ok;

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      localparam logic [SEL_W-1:0] c_ch_idx = SEL_W'(k);

      ch_state_e         state_q;
      ch_state_e         state_d;
      logic [DATA_W-1:0] data_q;
      logic [DATA_W-1:0] data_d;

      // A channel can take a word if it is empty or its word leaves this cycle.
      assign w_free[k] = (state_q == CH_EMPTY) || out_ready[k];
      assign w_load[k] = w_accept && (in_bcast || (w_sel_ok && (in_sel == c_ch_idx)));

      // Next state: a load wins over a drain so drain+load keeps the channel full.
      always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (w_load[k]) begin
          state_d = CH_FULL;
          data_d  = in_data;
        end else if ((state_q == CH_FULL) && out_ready[k]) begin
          state_d = CH_EMPTY;
        end
      end

      // Channel register; data is kept after drain so out_data shows the last word.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= CH_EMPTY;
          data_q  <= '0;
        end else begin
          state_q <= state_d;
          data_q  <= data_d;
        end
      end

      assign out_valid[k]                     = (state_q == CH_FULL);
      assign out_data[k*DATA_W +: DATA_W]     = data_q;
    end
  endgenerate

  // Saturating drop counter for words accepted with an out-of-range select.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (w_drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire
